// File: rtl/cp0_pkg.sv
// Shared CP0 register numbers, field offsets and the interrupt priority helper
// used by the interrupt-capable coprocessor-0 block.
package cp0_pkg;

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;

    localparam int IE_BIT     = 0;
    localparam int EXL_BIT    = 1;
    localparam int IM_LSB     = 8;
    localparam int IRQ_ID_LSB = 16;
    localparam int EXC_LSB    = 2;

    localparam logic [4:0] EXC_INT = 5'd0;

    // Lowest set bit wins: line 0 has the highest priority.
    function automatic logic [4:0] lowest_index(input logic [7:0] vec);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 5'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/cp0_irq_if.sv
// CPU-side connection of the coprocessor-0 block: MFC0/MTC0 access, ERET,
// PC redirect outputs and the device interrupt request lines.
interface cp0_irq_if #(
    parameter int NUM_IRQ = 8
);
    logic [31:0]        rd_data;
    logic [29:0]        EPC;
    logic [29:0]        handler_pc;
    logic               TakenInterrupt;
    logic [31:0]        wr_data;
    logic [4:0]         regnum;
    logic [29:0]        next_pc;
    logic               MTC0;
    logic               ERET;
    logic [NUM_IRQ-1:0] irq;

    modport master (
        input  rd_data, EPC, handler_pc, TakenInterrupt,
        output wr_data, regnum, next_pc, MTC0, ERET, irq
    );

    modport slave (
        output rd_data, EPC, handler_pc, TakenInterrupt,
        input  wr_data, regnum, next_pc, MTC0, ERET, irq
    );
endinterface

// File: rtl/cp0_irq_capture.sv
// Per-line interrupt pending capture: level lines follow irq, edge lines latch
// a rising edge until software clears them with a write-1-to-clear to Cause.
module cp0_irq_capture #(
    parameter int         NUM_IRQ   = 8,
    parameter logic [7:0] EDGE_MASK = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               clr_en,
    input  logic [NUM_IRQ-1:0] clr_mask,
    output logic [NUM_IRQ-1:0] ip
);

    logic [NUM_IRQ-1:0] ip_r;
    logic [NUM_IRQ-1:0] irq_q_r;
    logic [NUM_IRQ-1:0] ip_nxt_s;

    // Next pending value; a new edge overrides a clear on the same cycle.
    always_comb begin
        ip_nxt_s = {NUM_IRQ{1'b0}};
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (EDGE_MASK[i]) begin
                ip_nxt_s[i] = (irq[i] & ~irq_q_r[i]) |
                              (ip_r[i] & ~(clr_en & clr_mask[i]));
            end else begin
                ip_nxt_s[i] = irq[i];
            end
        end
    end

    // Pending and previous-sample registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ip_r    <= {NUM_IRQ{1'b0}};
            irq_q_r <= {NUM_IRQ{1'b0}};
        end else begin
            ip_r    <= ip_nxt_s;
            irq_q_r <= irq;
        end
    end

    assign ip = ip_r;

endmodule

// File: rtl/cp0_irq.sv
// Coprocessor 0 with NUM_IRQ prioritised, maskable interrupt lines: holds
// Status, Cause and EPC, and requests the PC redirect to the handler.
module cp0_irq
    import cp0_pkg::*;
#(
    parameter int          NUM_IRQ    = 8,
    parameter logic [7:0]  EDGE_MASK  = 8'h00,
    parameter logic [29:0] HANDLER_PC = 30'h20000060
) (
    input  logic      clk,
    input  logic      reset,
    cp0_irq_if.slave  bus
);

    logic               ie_r;
    logic               exl_r;
    logic [NUM_IRQ-1:0] im_r;
    logic [29:0]        epc_r;
    logic [4:0]         irq_id_r;

    logic [NUM_IRQ-1:0] ip_s;
    logic [NUM_IRQ-1:0] pend_s;
    logic [4:0]         pend_id_s;
    logic               taken_s;
    logic               wr_status_s;
    logic               wr_cause_s;
    logic               wr_epc_s;
    logic [31:0]        rd_s;

    assign wr_status_s = bus.MTC0 & (bus.regnum == REG_STATUS);
    assign wr_cause_s  = bus.MTC0 & (bus.regnum == REG_CAUSE);
    assign wr_epc_s    = bus.MTC0 & (bus.regnum == REG_EPC);

    cp0_irq_capture #(
        .NUM_IRQ   (NUM_IRQ),
        .EDGE_MASK (EDGE_MASK)
    ) u_capture (
        .clk      (clk),
        .reset    (reset),
        .irq      (bus.irq),
        .clr_en   (wr_cause_s),
        .clr_mask (bus.wr_data[IM_LSB +: NUM_IRQ]),
        .ip       (ip_s)
    );

    assign pend_s    = ip_s & im_r;
    assign pend_id_s = lowest_index(8'(pend_s));
    assign taken_s   = ie_r & ~exl_r & (|pend_s);

    // Status, EPC and IRQ_ID; later assignments win, so a taken interrupt
    // overrides an MTC0 on the overlapping EXL and EPC fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie_r     <= 1'b0;
            exl_r    <= 1'b0;
            im_r     <= {NUM_IRQ{1'b0}};
            epc_r    <= 30'h0;
            irq_id_r <= 5'd0;
        end else begin
            if (bus.ERET) begin
                exl_r <= 1'b0;
            end
            if (wr_status_s) begin
                ie_r  <= bus.wr_data[IE_BIT];
                exl_r <= bus.wr_data[EXL_BIT];
                im_r  <= bus.wr_data[IM_LSB +: NUM_IRQ];
            end
            if (wr_epc_s) begin
                epc_r <= bus.wr_data[31:2];
            end
            if (taken_s) begin
                exl_r    <= 1'b1;
                epc_r    <= bus.next_pc;
                irq_id_r <= pend_id_s;
            end
        end
    end

    // MFC0 read mux, combinational from registered state.
    always_comb begin
        rd_s = 32'h0;
        case (bus.regnum)
            REG_STATUS: begin
                rd_s[IE_BIT]               = ie_r;
                rd_s[EXL_BIT]              = exl_r;
                rd_s[IM_LSB +: NUM_IRQ]    = im_r;
            end
            REG_CAUSE: begin
                rd_s[IM_LSB +: NUM_IRQ]    = ip_s;
                rd_s[IRQ_ID_LSB +: 5]      = irq_id_r;
                rd_s[EXC_LSB +: 5]         = EXC_INT;
            end
            REG_EPC: begin
                rd_s = {epc_r, 2'b00};
            end
            default: begin
                rd_s = 32'h0;
            end
        endcase
    end

    assign bus.rd_data        = rd_s;
    assign bus.EPC            = epc_r;
    assign bus.handler_pc     = HANDLER_PC;
    assign bus.TakenInterrupt = taken_s;

endmodule

// File: doc/cp0_irq.md
# cp0_irq

Parametrised coprocessor-0 successor for the single-cycle MIPS machine. Replaces the one-line timer-only interrupt scheme with `NUM_IRQ` prioritised, maskable interrupt lines, each selectable as level- or edge-sensitive. It holds Status, Cause and EPC, and drives the PC-redirect request (`TakenInterrupt`) and the `eret` return address into the PC mux chain.

## Interface
- `NUM_IRQ`, 8: number of interrupt lines, legal range 1..8.
- `EDGE_MASK`, 8'h00: bit i=1 makes line i rising-edge sensitive; bit i=0 makes it level sensitive.
- `HANDLER_PC`, 30'h20000060: word address of the handler, driven on `handler_pc`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `rd_data` output 32: MFC0 read data for register `regnum`.
- `EPC` output 30: saved return word address (PC[31:2]).
- `handler_pc` output 30: constant `HANDLER_PC`.
- `TakenInterrupt` output 1: redirect PC to handler this cycle.
- `wr_data` input 32: MTC0 write data (rt value).
- `regnum` input 5: CP0 register number, shared by read and write.
- `next_pc` input 30: word address of the next sequential/branch PC, pre-interrupt.
- `MTC0` input 1: write enable.
- `ERET` input 1: return-from-exception.
- `irq` input NUM_IRQ: device interrupt requests.

## Operation
- Status (reg 12):
  - [0] IE.
  - [1] EXL.
  - [8+NUM_IRQ-1:8] IM (per-line mask).
  - All other bits read 0.
- Cause (reg 13):
  - [8+NUM_IRQ-1:8] IP (pending).
  - [20:16] IRQ_ID, the line last taken.
  - [6:2] ExcCode, always 0 (interrupt).
  - Other bits read 0.
- EPC (reg 14): rd_data = {EPC, 2'b00}. Any other regnum reads 0; writes to it are ignored.
- Pending capture, per line, every edge:
  - Level line: IP[i] <= irq[i].
  - Edge line: IP[i] is set when irq[i]=1 and the previous sample was 0, and stays set until cleared.
  - Clear: MTC0 to reg 13 with wr_data[8+i]=1 (write-1-to-clear).
  - Set and clear on the same edge: set wins.
  - MTC0 to Cause never affects level lines, IRQ_ID or ExcCode.
- Request: TakenInterrupt = IE & ~EXL & |(IP & IM), combinational from registered state only.
- On an edge with TakenInterrupt=1:
  - EXL <= 1.
  - EPC <= next_pc.
  - IRQ_ID <= lowest index i with IP[i]&IM[i].
- ERET=1: EXL <= 0. The machine selects EPC as the PC source.
- MTC0 to reg 12 writes IE, EXL and IM. MTC0 to reg 14 writes EPC <= wr_data[31:2].
- Simultaneous events:
  - Taken and MTC0 on the same edge: the instruction retires, so the MTC0 write applies. On overlapping fields the taken event wins: EXL=1, EPC=next_pc.
  - ERET with EXL=1 implies TakenInterrupt=0, so there is no conflict.
  - ERET with EXL=0 is harmless: EXL stays 0.
- Reset, asynchronous, at any point including mid-handler:
  - Status=0, IP=0, IRQ_ID=0, EPC=0, edge-sample registers=0.
  - Hence TakenInterrupt=0, and rd_data reads 0 for all registers.

## Timing
- irq sampled at edge t, so IP is visible after t.
- TakenInterrupt is high during cycle t→t+1, provided unmasked and IE & ~EXL.
- At edge t+1: PC takes handler_pc, EPC and EXL update. Total irq-to-redirect latency: 2 edges.
- TakenInterrupt drops in the cycle after it is taken because EXL=1. It cannot re-fire until ERET or an MTC0 clears EXL.
- MFC0 read is combinational from registers, so a value written at edge t is readable in cycle t→t+1.
- Level lines must be held by the device until the handler acknowledges the device. Dropping earlier loses the request, which is acceptable.

## Structure
- Package `cp0_pkg` holds:
  - Register numbers: STATUS=12, CAUSE=13, EPC=14.
  - Field offsets: IE=0, EXL=1, IM/IP base=8, IRQ_ID lsb=16, ExcCode lsb=2.
  - EXC_INT=0.
- Sub-module `cp0_irq_capture #(NUM_IRQ, EDGE_MASK)`:
  - Holds the IP and edge-sample registers and the clear logic.
  - Outputs IP.
- The top level holds Status, EPC, IRQ_ID, the priority encoder and the read mux.

## Test plan
- Reset mid-handler (EXL=1, EPC=0x00400010): assert reset → all reads 0, TakenInterrupt=0 immediately, without waiting for a clock.
- Level line 3, with Status=0x0801 (IE, IM3): raise irq[3] before edge t → TakenInterrupt=1 in cycle t+1. At edge t+1: EPC=next_pc (0x100005 word, i.e. read 0x00400014), Cause=0x00030800, Status=0x0803.
- Priority: lines 2 and 5 pending, both unmasked → IRQ_ID=2 on take. With IM2 cleared → IRQ_ID=5.
- Edge line 0 (EDGE_MASK=1): pulse irq[0] for one cycle while IE=0 → IP0 stays set. Set IE → taken. MTC0 Cause with 0x100 → IP0=0. A new pulse on the clearing edge leaves IP0=1.
- ERET after handling → EXL=0 the next cycle. A still-asserted level line re-fires TakenInterrupt in that cycle.
- MTC0 writing Status=0 in the same cycle as a take → after the edge EXL=1, IE=0, IM=0, and EPC holds next_pc.
